// File: rtl/fast_window_gen.sv
// fast_window_gen: raster-to-window front end for the FAST corner scorer.
// Buffers KERNEL_SIZE-1 lines and emits a registered KERNEL_SIZE x KERNEL_SIZE
// window, flattened as [row][col][bit] with row 0 / col 0 the oldest.
// Optional macro FAST_WIN_COORD_EN adds out_row/out_col centre coordinates.
module fast_window_gen #(
  parameter int unsigned PIXEL_DEPTH = 8,
  parameter int unsigned KERNEL_SIZE = 7,
  parameter int unsigned IMG_WIDTH   = 640,
  parameter int unsigned IMG_HEIGHT  = 480
) (
  input  logic                                             clk,
  input  logic                                             rst_n,
  input  logic                                             in_valid,
  input  logic                                             in_sof,
  input  logic [PIXEL_DEPTH-1:0]                           in_pixel,
  output logic                                             out_valid,
  output logic                                             out_last,
`ifdef FAST_WIN_COORD_EN
  output logic [$clog2(IMG_HEIGHT)-1:0]                    out_row,
  output logic [$clog2(IMG_WIDTH)-1:0]                     out_col,
`endif
  output logic [KERNEL_SIZE*KERNEL_SIZE*PIXEL_DEPTH-1:0]   out_data
);

  localparam int unsigned ColW = $clog2(IMG_WIDTH);
  localparam int unsigned RowW = $clog2(IMG_HEIGHT);
  localparam int unsigned Half = KERNEL_SIZE / 2;
  localparam int unsigned WinW = KERNEL_SIZE * KERNEL_SIZE * PIXEL_DEPTH;

  logic [ColW-1:0] col_q, col_d, cur_col;
  logic [RowW-1:0] row_q, row_d, cur_row;
  logic [WinW-1:0] win_q, win_d, out_data_q;
  logic            out_valid_q, out_last_q;
  logic            emit, frame_end;
  logic [PIXEL_DEPTH-1:0] new_col [KERNEL_SIZE];

  // Line buffers: line 0 is the oldest; storage has no reset.
  logic [PIXEL_DEPTH-1:0] lb_q [KERNEL_SIZE-1][IMG_WIDTH];

`ifdef FAST_WIN_COORD_EN
  logic [RowW-1:0] out_row_q;
  logic [ColW-1:0] out_col_q;
`endif

  // Position of the pixel being accepted and the next-state counters.
  always_comb begin
    cur_col = in_sof ? '0 : col_q;
    cur_row = in_sof ? '0 : row_q;
    col_d   = col_q;
    row_d   = row_q;
    if (in_valid) begin
      if (cur_col == ColW'(IMG_WIDTH - 1)) begin
        col_d = '0;
        row_d = (cur_row == RowW'(IMG_HEIGHT - 1)) ? '0 : cur_row + RowW'(1);
      end else begin
        col_d = cur_col + ColW'(1);
        row_d = cur_row;
      end
    end
    emit      = in_valid && (cur_row >= RowW'(KERNEL_SIZE - 1)) &&
                (cur_col >= ColW'(KERNEL_SIZE - 1));
    frame_end = (cur_row == RowW'(IMG_HEIGHT - 1)) && (cur_col == ColW'(IMG_WIDTH - 1));
  end

  // New column: buffered lines (oldest first) topped by the incoming pixel; shift into window.
  always_comb begin
    for (int i = 0; i < int'(KERNEL_SIZE) - 1; i++) begin
      new_col[i] = lb_q[i][cur_col];
    end
    new_col[KERNEL_SIZE-1] = in_pixel;
    win_d = win_q;
    if (in_valid) begin
      for (int r = 0; r < int'(KERNEL_SIZE); r++) begin
        for (int c = 0; c < int'(KERNEL_SIZE) - 1; c++) begin
          win_d[(r*KERNEL_SIZE+c)*PIXEL_DEPTH +: PIXEL_DEPTH] =
            win_q[(r*KERNEL_SIZE+c+1)*PIXEL_DEPTH +: PIXEL_DEPTH];
        end
        win_d[(r*KERNEL_SIZE+KERNEL_SIZE-1)*PIXEL_DEPTH +: PIXEL_DEPTH] = new_col[r];
      end
    end
  end

  // Line buffers shift up one line at the accepted column.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      for (int i = 0; i < int'(KERNEL_SIZE) - 2; i++) begin
        lb_q[i][cur_col] <= lb_q[i+1][cur_col];
      end
      lb_q[KERNEL_SIZE-2][cur_col] <= in_pixel;
    end
  end

  // Counters, window register and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_q       <= '0;
      row_q       <= '0;
      win_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
`ifdef FAST_WIN_COORD_EN
      out_row_q   <= '0;
      out_col_q   <= '0;
`endif
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      win_q       <= win_d;
      out_valid_q <= emit;
      out_last_q  <= emit && frame_end;
      if (emit) begin
        out_data_q <= win_d;
`ifdef FAST_WIN_COORD_EN
        out_row_q  <= cur_row - RowW'(Half);
        out_col_q  <= cur_col - ColW'(Half);
`endif
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_data  = out_data_q;
`ifdef FAST_WIN_COORD_EN
  assign out_row   = out_row_q;
  assign out_col   = out_col_q;
`endif

endmodule

// File: tb/tb_fast_window_gen.sv
// Self-checking bench for fast_window_gen on an 8x8 image.
// Reference: a frame image array plus the window-extraction rule.
module tb_fast_window_gen;

  localparam int P = 8;
  localparam int K = 7;
  localparam int W = 8;
  localparam int H = 8;
  localparam int WinW = K * K * P;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_sof;
  logic [P-1:0]    in_pixel;
  logic            out_valid;
  logic            out_last;
  logic [WinW-1:0] out_data;
`ifdef FAST_WIN_COORD_EN
  logic [2:0]      out_row;
  logic [2:0]      out_col;
`endif

  fast_window_gen #(
    .PIXEL_DEPTH (P),
    .KERNEL_SIZE (K),
    .IMG_WIDTH   (W),
    .IMG_HEIGHT  (H)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .in_pixel  (in_pixel),
    .out_valid (out_valid),
    .out_last  (out_last),
`ifdef FAST_WIN_COORD_EN
    .out_row   (out_row),
    .out_col   (out_col),
`endif
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string nm, input logic [WinW-1:0] act, input logic [WinW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model state
  logic [P-1:0]    img [H][W];
  int              mr, mc, acc_cnt;
  logic            e_valid, e_last;
  logic [WinW-1:0] e_data;
  int              e_r, e_c;

  always @(posedge clk) begin
    if (!rst_n) begin
      mr = 0; mc = 0;
      e_valid = 1'b0; e_last = 1'b0; e_data = '0; e_r = 0; e_c = 0;
    end else begin
      e_valid = 1'b0;
      e_last  = 1'b0;
      if (in_valid) begin
        if (in_sof) begin
          mr = 0; mc = 0;
        end
        img[mr][mc] = in_pixel;
        acc_cnt++;
        if (mr >= K - 1 && mc >= K - 1) begin
          e_valid = 1'b1;
          e_r = mr - 3;
          e_c = mc - 3;
          for (int i = 0; i < K; i++)
            for (int j = 0; j < K; j++)
              e_data[(i*K+j)*P +: P] = img[e_r-3+i][e_c-3+j];
          e_last = (e_r == H - 4) && (e_c == W - 4);
        end
        mc++;
        if (mc == W) begin
          mc = 0;
          mr++;
          if (mr == H) mr = 0;
        end
      end
    end
  end

  // Per-cycle compare plus a log of emitted windows
  bit              chk_en = 1'b0;
  int              win_cnt, last_cnt, first_acc;
  logic [WinW-1:0] log_data [$];
  bit              log_last [$];
  int              log_rc   [$];

  always @(negedge clk) begin
    if (chk_en) begin
      check("out_valid", WinW'(out_valid), WinW'(e_valid));
      check("out_last", WinW'(out_last), WinW'(e_last));
      check("out_data", out_data, e_data);
`ifdef FAST_WIN_COORD_EN
      if (!rst_n) begin
        check("out_row_rst", WinW'(out_row), '0);
        check("out_col_rst", WinW'(out_col), '0);
      end else if (e_valid) begin
        check("out_row", WinW'(out_row), WinW'(e_r));
        check("out_col", WinW'(out_col), WinW'(e_c));
      end
      if (out_valid === 1'b1) log_rc.push_back(int'(out_row) * 16 + int'(out_col));
`endif
      if (out_valid === 1'b1) begin
        if (win_cnt == 0) first_acc = acc_cnt;
        win_cnt++;
        if (out_last === 1'b1) last_cnt++;
        log_data.push_back(out_data);
        log_last.push_back(out_last);
      end
    end
  end

  task automatic clear_log();
    win_cnt = 0; last_cnt = 0; first_acc = -1; acc_cnt = 0;
    log_data.delete(); log_last.delete(); log_rc.delete();
  endtask

  task automatic drive_px(input logic [P-1:0] px, input bit sof, input bit gaps);
    if (gaps) begin
      for (int g = 0; g < 4 && $urandom_range(1) == 0; g++) begin
        in_valid = 1'b0; in_sof = 1'b0; in_pixel = 8'($urandom);
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b1; in_sof = sof; in_pixel = px;
    @(posedge clk); #1;
    in_valid = 1'b0; in_sof = 1'b0;
  endtask

  task automatic send(input int base, input bit sof, input bit gaps, input bit rnd,
                      input int npix);
    for (int k = 0; k < npix; k++) begin
      logic [P-1:0] px;
      px = rnd ? 8'($urandom) : 8'(base + 16 * (k / W) + (k % W));
      drive_px(px, sof && (k == 0), gaps);
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0; in_sof = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  function automatic logic [WinW-1:0] pix(input logic [WinW-1:0] w, input int r, input int c);
    return WinW'(w[(r*K+c)*P +: P]);
  endfunction

  task automatic check_frames(input string nm, input int nwin, input int nlast);
    check({nm, "_win_count"}, WinW'(win_cnt), WinW'(nwin));
    check({nm, "_last_count"}, WinW'(last_cnt), WinW'(nlast));
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_pixel = '0;
    clear_log();
    @(posedge clk); #1;
    chk_en = 1'b1;
    idle(2);
    rst_n = 1'b1;
    idle(2);

    // Basic frame
    clear_log();
    send(0, 1'b1, 1'b0, 1'b0, W * H);
    idle(3);
    check_frames("basic", 4, 1);
    check("basic_first_at_55", WinW'(first_acc), WinW'(55));
    if (log_data.size() == 4) begin
      check("basic_w0_c33", pix(log_data[0], 3, 3), WinW'(8'h33));
      check("basic_w0_c00", pix(log_data[0], 0, 0), WinW'(8'h00));
      check("basic_w0_c66", pix(log_data[0], 6, 6), WinW'(8'h66));
      check("basic_w3_c33", pix(log_data[3], 3, 3), WinW'(8'h44));
      check("basic_w3_last", WinW'(log_last[3]), WinW'(1));
      check("basic_w2_last", WinW'(log_last[2]), WinW'(0));
`ifdef FAST_WIN_COORD_EN
      check("coord_w0", WinW'(log_rc[0]), WinW'(8'h33));
      check("coord_w1", WinW'(log_rc[1]), WinW'(8'h34));
      check("coord_w2", WinW'(log_rc[2]), WinW'(8'h43));
      check("coord_w3", WinW'(log_rc[3]), WinW'(8'h44));
`endif
    end

    // Input gaps
    clear_log();
    send(0, 1'b1, 1'b1, 1'b0, W * H);
    idle(3);
    check_frames("gaps", 4, 1);
    if (log_data.size() == 4) begin
      check("gaps_w0_c33", pix(log_data[0], 3, 3), WinW'(8'h33));
      check("gaps_w3_c33", pix(log_data[3], 3, 3), WinW'(8'h44));
    end

    // Reset mid-frame, then a fresh frame without in_sof
    send(8'h40, 1'b1, 1'b0, 1'b0, 30);
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    clear_log();
    send(0, 1'b0, 1'b0, 1'b0, W * H);
    idle(3);
    check_frames("reset", 4, 1);
    if (log_data.size() == 4) check("reset_w0_c33", pix(log_data[0], 3, 3), WinW'(8'h33));

    // Sync abort on pixel 20 with random data, then a full frame
    clear_log();
    send(0, 1'b1, 1'b0, 1'b1, 20);
    send(0, 1'b1, 1'b0, 1'b0, W * H);
    idle(3);
    check_frames("abort", 4, 1);
    if (log_data.size() == 4) check("abort_w0_c33", pix(log_data[0], 3, 3), WinW'(8'h33));

    // Back-to-back frames, second without in_sof
    clear_log();
    send(0, 1'b1, 1'b0, 1'b0, W * H);
    send(8'h80, 1'b0, 1'b0, 1'b0, W * H);
    idle(3);
    check_frames("b2b", 8, 2);
    if (log_data.size() == 8) begin
      check("b2b_w4_c33", pix(log_data[4], 3, 3), WinW'(8'hB3));
      check("b2b_w7_last", WinW'(log_last[7]), WinW'(1));
    end

    // Random pixels with gaps, checked by the model only
    clear_log();
    send(0, 1'b1, 1'b1, 1'b1, W * H);
    send(0, 1'b0, 1'b1, 1'b1, W * H);
    idle(3);
    check_frames("random", 8, 2);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time limit
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/fast_window_gen.md
# fast_window_gen

Raster-to-window front end for the FAST corner scorer. Accepts one pixel per cycle in raster order with a valid qualifier. Buffers KERNEL_SIZE-1 image lines and emits a registered KERNEL_SIZE x KERNEL_SIZE neighbourhood whenever the full kernel lies inside the image. Output layout is exactly the packed window the corner scorer consumes, with PPC=1.

## Interface
- PIXEL_DEPTH, 8, bits per pixel
- KERNEL_SIZE, 7, window edge; only 7 is supported
- IMG_WIDTH, 640, pixels per line; must be at least KERNEL_SIZE
- IMG_HEIGHT, 480, lines per frame; must be at least KERNEL_SIZE
- clk  in  1  clock; all logic on posedge
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  pixel strobe; a pixel is accepted on every cycle it is high
- in_sof  in  1  start of frame; meaningful only with in_valid
- in_pixel  in  PIXEL_DEPTH  raster pixel
- out_valid  out  1  window strobe, single cycle
- out_last  out  1  high with out_valid for the final window of the frame
- out_data  out  KERNEL_SIZE x KERNEL_SIZE x PIXEL_DEPTH  packed window, [row][col]
  - row 0 is the oldest line; col 0 is the oldest pixel
  - [3][3] is the centre pixel

## Operation
- Position counters col (0..IMG_WIDTH-1) and row (0..IMG_HEIGHT-1) give the position of the pixel being accepted.
- Counters advance only on accepted pixels.
- col wraps at IMG_WIDTH-1 and increments row. At (IMG_HEIGHT-1, IMG_WIDTH-1) both counters wrap to 0; the next pixel is (0,0) of a new frame.
- in_sof with in_valid forces the accepted pixel to position (0,0), which aborts any frame in progress. in_sof without in_valid is ignored.
- Line buffers: KERNEL_SIZE-1 lines of IMG_WIDTH entries, indexed by col.
  - On acceptance, the column read from the buffers plus in_pixel forms a new KERNEL_SIZE-tall column.
  - That column shifts into the window register, and the buffers shift up one line at index col.
  - Line buffer storage is not reset.
- Emit condition: the accepted pixel at (r,c) has r ≥ KERNEL_SIZE-1 and c ≥ KERNEL_SIZE-1.
  - The emitted window centre is (r-3, c-3).
  - Windows never straddle a line boundary or a frame boundary, and never expose stale buffer contents.
- out_last: emitted window centre is (IMG_HEIGHT-4, IMG_WIDTH-4).
- No backpressure: the downstream block must consume every out_valid.

## Timing
- Latency is 1 cycle: out_valid/out_data/out_last are registered in the cycle after the qualifying pixel is accepted.
- out_valid is low in any cycle that follows a non-accepted or non-qualifying pixel.
- out_data holds its last value when out_valid is low.
- Windows per frame: (IMG_WIDTH-6)·(IMG_HEIGHT-6).
- Reset values: out_valid=0, out_last=0, out_data=0, window register=0, col=0, row=0.
- Reset mid-frame: the next accepted pixel is treated as (0,0) whether or not in_sof is asserted. No output until the qualifying position of the new frame.
- Simultaneous in_sof and frame-end wrap: in_sof wins, with the same result (0,0).

## Configuration
- FAST_WIN_COORD_EN defined:
  - Adds outputs out_row and out_col, each $clog2(IMG_HEIGHT) and $clog2(IMG_WIDTH) bits wide.
  - They carry the window centre coordinates and are registered with out_valid.
  - Both reset to 0.
- FAST_WIN_COORD_EN not defined: those ports and their registers do not exist. All other behaviour is identical.

## Test plan
- **Basic frame.** IMG_WIDTH=IMG_HEIGHT=8, pixel = 16·r+c, continuous in_valid, in_sof on the first pixel.
  - Exactly 4 out_valid pulses, the first one cycle after the 55th accepted pixel, (6,6).
  - First window: [3][3]=0x33, [0][0]=0x00, [6][6]=0x66.
  - out_last only on the 4th window, where [3][3]=0x44.
- **Input gaps.** Same frame with a random 50% in_valid duty.
  - Identical 4 windows in order.
  - No out_valid in cycles after idle inputs.
- **Reset mid-frame.** Assert rst_n=0 for 2 cycles after 30 pixels, then send a fresh frame without in_sof.
  - All outputs are 0 during reset.
  - Exactly 4 correct windows from the new frame.
- **Sync abort.** in_sof pulses on pixel 20 of a frame, then a full 8x8 frame follows.
  - No window from the aborted data.
  - 4 windows matching the restarted frame.
- **Back-to-back frames.** Two frames, the second with values +0x80, no gap and no second in_sof.
  - 8 windows total and two out_last pulses.
  - Second-frame first window [3][3]=0xB3.
- **Coordinates.** With FAST_WIN_COORD_EN, run the basic frame.
  - (out_row,out_col) = (3,3),(3,4),(4,3),(4,4).
